obuftds_bus_seq: RTL and testbench

- Multi-channel differential tristate output driver with a bus-turnaround sequencer.
- Drives NCH pad pairs from per-channel data bits:
  - registers data and tristate control per channel;
  - corrects polarity in logic for channels whose P/N pins are swapped on the board;
  - sequences enable/disable with programmable idle guard intervals.
- Sits between protocol logic and shared bidirectional or multi-drop differential lines.

---
 rtl/obuftds_pkg.sv | 18 +
 rtl/obuftds_pad_cell.sv | 39 +++
 rtl/obuftds_bus_seq.sv | 111 +++++++++++
 tb/tb_obuftds_bus_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/obuftds_pkg.sv
// Shared types and helpers for the differential tristate bus sequencer.
package obuftds_pkg;

  typedef enum logic [1:0] {
    HIZ   = 2'd0,
    LEAD  = 2'd1,
    DRIVE = 2'd2,
    TAIL  = 2'd3
  } state_t;

  // Guard counter width; at least one bit even when both guards are zero.
  function automatic int cnt_width(input int lead_cyc, input int tail_cyc);
    int m;
    m = (lead_cyc > tail_cyc) ? lead_cyc : tail_cyc;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/obuftds_pad_cell.sv
// One differential output channel: pad-packed data/tristate flops feeding a
// behavioural OBUFTDS, with optional P/N cross-connect for swapped board pins.
module obuftds_pad_cell #(
  parameter bit INV   = 1'b0,
  parameter bit RST_D = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  input  logic t,
  output wire  pad_p,
  output wire  pad_n
);

  (* IOB = "TRUE" *) logic d_q;
  (* IOB = "TRUE" *) logic t_q;

  // Reset releases the line at once, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= RST_D;
      t_q <= 1'b1;
    end else begin
      d_q <= d;
      t_q <= t;
    end
  end

  logic buf_o;
  logic buf_ob;

  assign buf_o  = d_q;
  assign buf_ob = ~d_q;

  // Swapped pins: the buffer's OB lands on the schematic P pin and vice versa.
  assign pad_p = t_q ? 1'bz : (INV ? buf_ob : buf_o);
  assign pad_n = t_q ? 1'bz : (INV ? buf_o : buf_ob);

endmodule

// File: rtl/obuftds_bus_seq.sv
// Multi-channel differential tristate driver with a bus-turnaround sequencer
// (HIZ -> LEAD guard -> DRIVE -> TAIL guard -> HIZ).
module obuftds_bus_seq
  import obuftds_pkg::*;
#(
  parameter int             NCH      = 4,
  parameter logic [NCH-1:0] INV_MASK = {NCH{1'b0}},
  parameter logic [NCH-1:0] IDLE_VAL = {NCH{1'b0}},
  parameter int             LEAD_CYC = 2,
  parameter int             TAIL_CYC = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           drive_req,
  input  logic [NCH-1:0] dat_i,
  output logic           drive_ack,
  output logic           busy,
  output wire  [NCH-1:0] O_P,
  output wire  [NCH-1:0] O_N
);

  localparam int CW = cnt_width(LEAD_CYC, TAIL_CYC);
  localparam logic [CW-1:0] LEAD_LD = (LEAD_CYC > 0) ? CW'(LEAD_CYC - 1) : '0;
  localparam logic [CW-1:0] TAIL_LD = (TAIL_CYC > 0) ? CW'(TAIL_CYC - 1) : '0;

  state_t         state;
  state_t         state_nx;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_nx;
  logic [NCH-1:0] d_nx;
  logic           t_nx;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      HIZ: begin
        if (drive_req) begin
          if (LEAD_CYC > 0) begin
            state_nx = LEAD;
            cnt_nx   = LEAD_LD;
          end else begin
            state_nx = DRIVE;
          end
        end
      end
      LEAD: begin
        // Losing the request during the lead guard skips DRIVE entirely.
        if (!drive_req) begin
          state_nx = (TAIL_CYC > 0) ? TAIL : HIZ;
          cnt_nx   = TAIL_LD;
        end else if (cnt == '0) begin
          state_nx = DRIVE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      DRIVE: begin
        if (!drive_req) begin
          state_nx = (TAIL_CYC > 0) ? TAIL : HIZ;
          cnt_nx   = TAIL_LD;
        end
      end
      TAIL: begin
        // Request is ignored here so HIZ always separates two ownerships.
        if (cnt == '0) begin
          state_nx = HIZ;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: begin
        state_nx = HIZ;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HIZ;
      cnt       <= '0;
      drive_ack <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      drive_ack <= (state_nx == DRIVE);
      busy      <= (state_nx != HIZ);
    end
  end

  // Pre-inverting swapped channels keeps the external line equal to dat_i.
  assign d_nx = ((state == DRIVE) ? dat_i : IDLE_VAL) ^ INV_MASK;
  assign t_nx = (state == HIZ);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    obuftds_pad_cell #(
      .INV   (INV_MASK[i]),
      .RST_D (IDLE_VAL[i] ^ INV_MASK[i])
    ) u_pad (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (d_nx[i]),
      .t     (t_nx),
      .pad_p (O_P[i]),
      .pad_n (O_N[i])
    );
  end

endmodule

// File: tb/tb_obuftds_bus_seq.sv
// Scoreboard bench for obuftds_bus_seq: two configurations share stimulus,
// a reference model queues expected responses and a monitor checks them.
module tb_obuftds_bus_seq;

  localparam logic [3:0] INV_A  = 4'b0101;
  localparam logic [3:0] IDLE_A = 4'b0110;
  localparam logic [3:0] INV_B  = 4'b0011;
  localparam logic [3:0] IDLE_B = 4'b1001;

  logic       clk;
  logic       rst_n;
  logic       drive_req;
  logic [3:0] dat_i;
  logic       ack_a, busy_a, ack_b, busy_b;
  wire  [3:0] o_p_a, o_n_a, o_p_b, o_n_b;

  // Pull-ups make a released pad read as P=1,N=1, which a driver never shows.
  for (genvar i = 0; i < 4; i++) begin : g_pu
    pullup (o_p_a[i]);
    pullup (o_n_a[i]);
    pullup (o_p_b[i]);
    pullup (o_n_b[i]);
  end

  obuftds_bus_seq #(
    .NCH(4), .INV_MASK(INV_A), .IDLE_VAL(IDLE_A), .LEAD_CYC(2), .TAIL_CYC(2)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .drive_req(drive_req), .dat_i(dat_i),
    .drive_ack(ack_a), .busy(busy_a), .O_P(o_p_a), .O_N(o_n_a)
  );

  obuftds_bus_seq #(
    .NCH(4), .INV_MASK(INV_B), .IDLE_VAL(IDLE_B), .LEAD_CYC(0), .TAIL_CYC(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .drive_req(drive_req), .dat_i(dat_i),
    .drive_ack(ack_b), .busy(busy_b), .O_P(o_p_b), .O_N(o_n_b)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ownership phases tracked as cycles remaining.
  // Phase 0 released, 1 lead guard, 2 owning, 3 tail guard.
  logic [9:0] exp_qa[$];
  logic [9:0] exp_qb[$];
  int ph[2];
  int left[2];

  task automatic model_step(input int k, input int lc, input int tc,
                            input logic [3:0] idle, output logic [9:0] e);
    int old;
    logic [3:0] v, p, n;
    old = ph[k];
    case (old)
      0: if (drive_req) begin
        if (lc > 0) begin ph[k] = 1; left[k] = lc; end
        else ph[k] = 2;
      end
      1: if (!drive_req) begin
        if (tc > 0) begin ph[k] = 3; left[k] = tc; end
        else ph[k] = 0;
      end else begin
        left[k]--;
        if (left[k] == 0) ph[k] = 2;
      end
      2: if (!drive_req) begin
        if (tc > 0) begin ph[k] = 3; left[k] = tc; end
        else ph[k] = 0;
      end
      default: begin
        left[k]--;
        if (left[k] == 0) ph[k] = 0;
      end
    endcase
    if (old == 0) begin
      p = 4'hF;
      n = 4'hF;
    end else begin
      v = (old == 2) ? dat_i : idle;
      p = v;
      n = ~v;
    end
    e = {ph[k] == 2, ph[k] != 0, p, n};
  endtask

  initial begin
    logic [9:0] e;
    ph = '{0, 0};
    left = '{0, 0};
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        ph = '{0, 0};
        left = '{0, 0};
        exp_qa.delete();
        exp_qb.delete();
      end else begin
        model_step(0, 2, 2, IDLE_A, e);
        exp_qa.push_back(e);
        model_step(1, 0, 0, IDLE_B, e);
        exp_qb.push_back(e);
      end
    end
  end

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("reset_a", {ack_a, busy_a, o_p_a, o_n_a}, 10'h0FF);
        check("reset_b", {ack_b, busy_b, o_p_b, o_n_b}, 10'h0FF);
      end else begin
        if (exp_qa.size() > 0) check("seq_a", {ack_a, busy_a, o_p_a, o_n_a}, exp_qa.pop_front());
        if (exp_qb.size() > 0) check("seq_b", {ack_b, busy_b, o_p_b, o_n_b}, exp_qb.pop_front());
      end
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic req, input logic [3:0] dat, input int n);
    drive_req = req;
    dat_i = dat;
    cyc(n);
  endtask

  initial begin
    logic [3:0] dq_a;
    rst_n = 1'b0;
    drive_req = 1'b1;
    dat_i = 4'h0;
    cyc(3);
    rst_n = 1'b1;

    // Alternating words: 1 HIZ + 2 lead cycles, then 5 owned cycles on dut_a.
    for (int i = 0; i < 8; i++) drive(1'b1, (i % 2 == 0) ? 4'hA : 4'h5, 1);
    drive(1'b0, 4'h0, 6);

    // Request dropped after one lead cycle.
    drive(1'b1, 4'h3, 2);
    drive(1'b0, 4'hC, 6);

    // Reassert during tail guard.
    drive(1'b1, 4'h7, 8);
    drive(1'b0, 4'h1, 1);
    drive(1'b1, 4'hE, 6);
    drive(1'b0, 4'h0, 6);

    // All-ones word: swapped channels carry inverted data into the buffer.
    drive(1'b1, 4'hF, 6);
    dq_a = {dut_a.g_ch[3].u_pad.d_q, dut_a.g_ch[2].u_pad.d_q,
            dut_a.g_ch[1].u_pad.d_q, dut_a.g_ch[0].u_pad.d_q};
    check("dq_swap_a", {6'd0, dq_a}, {6'd0, 4'hF ^ INV_A});
    drive(1'b0, 4'h0, 6);

    // Single-cycle request pulse.
    drive(1'b1, 4'h9, 1);
    drive(1'b0, 4'h6, 5);

    // Reset asserted while both configurations are driving.
    drive(1'b1, 4'hB, 6);
    rst_n = 1'b0;
    #1;
    check("async_rst_a", {ack_a, busy_a, o_p_a, o_n_a}, 10'h0FF);
    check("async_rst_b", {ack_b, busy_b, o_p_b, o_n_b}, 10'h0FF);
    cyc(2);
    rst_n = 1'b1;
    drive(1'b0, 4'h0, 6);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) drive_req = ~drive_req;
      dat_i = 4'($urandom_range(0, 15));
      cyc(1);
    end

    drive(1'b0, 4'h0, 8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
